march_controller: RTL and testbench

MARCH_CONTROLLER -- requirements
Module: march_controller

---
 rtl/march_pkg.sv | 27 ++
 rtl/march_rom.sv | 22 ++
 rtl/march_controller.sv | 158 +++++++++++++++
 tb/tb_march_controller.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/march_pkg.sv
// Shared types for the March C- controller: FSM states, element count and
// the per-element descriptor returned by march_rom.
package march_pkg;

  localparam int NUM_ELEMS = 6;
  localparam int ELEM_W    = 3;
  localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(NUM_ELEMS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_READ,
    ST_CMP,
    ST_WRITE,
    ST_STEP,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic dir_up;   // 1 = ascending addresses
    logic rd_en;
    logic rd_val;   // expected background (replicated over the data width)
    logic wr_en;
    logic wr_val;   // written background (replicated over the data width)
  } elem_desc_t;

endpackage

// File: rtl/march_rom.sv
// March C- element table: element index -> direction and read/write operations.
module march_rom
  import march_pkg::*;
(
  input  logic [ELEM_W-1:0] elem_i,
  output elem_desc_t        desc_o
);

  always_comb begin
    desc_o = '0;
    unique case (elem_i)
      3'd0:    desc_o = '{dir_up: 1'b1, rd_en: 1'b0, rd_val: 1'b0, wr_en: 1'b1, wr_val: 1'b0};
      3'd1:    desc_o = '{dir_up: 1'b1, rd_en: 1'b1, rd_val: 1'b0, wr_en: 1'b1, wr_val: 1'b1};
      3'd2:    desc_o = '{dir_up: 1'b1, rd_en: 1'b1, rd_val: 1'b1, wr_en: 1'b1, wr_val: 1'b0};
      3'd3:    desc_o = '{dir_up: 1'b0, rd_en: 1'b1, rd_val: 1'b0, wr_en: 1'b1, wr_val: 1'b1};
      3'd4:    desc_o = '{dir_up: 1'b0, rd_en: 1'b1, rd_val: 1'b1, wr_en: 1'b1, wr_val: 1'b0};
      3'd5:    desc_o = '{dir_up: 1'b1, rd_en: 1'b1, rd_val: 1'b0, wr_en: 1'b0, wr_val: 1'b0};
      default: desc_o = '0;
    endcase
  end

endmodule

// File: rtl/march_controller.sv
// March C- memory-test controller driving an external address generator.
// Define MARCH_STOP_ON_FAIL_EN to end the run at the first read mismatch.
module march_controller
  import march_pkg::*;
#(
  parameter int A_WIDTH = 4,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               addr_reset,
  output logic               addr_preset,
  output logic               addr_en,
  output logic               addr_up_down,
  input  logic [A_WIDTH-1:0] addr,
  input  logic               addr_carry,
  output logic               mem_re,
  output logic               mem_we,
  output logic [D_WIDTH-1:0] mem_wdata,
  input  logic [D_WIDTH-1:0] mem_rdata,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [A_WIDTH-1:0] fail_addr,
  output logic [2:0]         fail_elem
);

  state_e              state_q, state_d;
  logic [ELEM_W-1:0]   elem_q, elem_d;
  logic                last_q, last_d;
  logic                fail_q, fail_d;
  logic [A_WIDTH-1:0]  fail_addr_q, fail_addr_d;
  logic [2:0]          fail_elem_q, fail_elem_d;
  elem_desc_t          desc;
  logic                mismatch;
  logic                at_last;

  march_rom u_rom (
    .elem_i (elem_q),
    .desc_o (desc)
  );

  assign mismatch = (state_q == ST_CMP) && (mem_rdata != {D_WIDTH{desc.rd_val}});
  // A carry arriving in the STEP cycle itself still ends the element.
  assign at_last  = last_q | addr_carry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      elem_q      <= '0;
      last_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      elem_q      <= elem_d;
      last_q      <= last_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d     = state_q;
    elem_d      = elem_q;
    last_d      = last_q | addr_carry;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_INIT;
          elem_d      = '0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
        end
      end
      ST_INIT: begin
        last_d  = addr_carry;
        state_d = desc.rd_en ? ST_READ : ST_WRITE;
      end
      ST_READ: state_d = ST_CMP;
      ST_CMP: begin
        if (mismatch && !fail_q) begin
          fail_d      = 1'b1;
          fail_addr_d = addr;
          fail_elem_d = elem_q;
        end
        state_d = desc.wr_en ? ST_WRITE : ST_STEP;
`ifdef MARCH_STOP_ON_FAIL_EN
        if (mismatch) state_d = ST_DONE;
`endif
      end
      ST_WRITE: state_d = ST_STEP;
      ST_STEP: begin
        if (!at_last) begin
          state_d = desc.rd_en ? ST_READ : ST_WRITE;
        end else if (elem_q == LAST_ELEM) begin
          state_d = ST_DONE;
        end else begin
          elem_d  = elem_q + 1'b1;
          state_d = ST_INIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_reset   = 1'b0;
    addr_preset  = 1'b0;
    addr_en      = 1'b0;
    addr_up_down = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        busy        = 1'b1;
        addr_reset  = desc.dir_up;
        addr_preset = ~desc.dir_up;
      end
      ST_READ: begin
        busy   = 1'b1;
        mem_re = 1'b1;
      end
      ST_CMP: busy = 1'b1;
      ST_WRITE: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = {D_WIDTH{desc.wr_val}};
      end
      ST_STEP: begin
        busy = 1'b1;
        if (!at_last) begin
          addr_en      = 1'b1;
          addr_up_down = desc.dir_up;
        end
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;

endmodule

// File: tb/tb_march_controller.sv
// Bench for march_controller: external address generator and memory models,
// plus a cycle-by-cycle expected trace derived from the March C- algorithm.
module tb_march_controller;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          addr_reset, addr_preset, addr_en, addr_up_down;
  logic [AW-1:0] gen_addr;
  logic          gen_carry;
  logic          mem_re, mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;

  always #5 clk = ~clk;

  march_controller #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .addr_reset   (addr_reset),
    .addr_preset  (addr_preset),
    .addr_en      (addr_en),
    .addr_up_down (addr_up_down),
    .addr         (gen_addr),
    .addr_carry   (gen_carry),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .fail_addr    (fail_addr),
    .fail_elem    (fail_elem)
  );

  // Stuck-at fault on one memory bit
  logic          flt_en;
  logic [AW-1:0] flt_addr;
  int            flt_bit;
  logic          flt_val;

  function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (flt_en && a == flt_addr) r[flt_bit] = flt_val;
    return r;
  endfunction

  // Address generator: carry pulses on the first cycle at the terminal address.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      gen_addr  <= '0;
      gen_carry <= 1'b0;
    end else if (addr_reset) begin
      gen_addr  <= '0;
      gen_carry <= 1'b0;
    end else if (addr_preset) begin
      gen_addr  <= '1;
      gen_carry <= 1'b0;
    end else if (addr_en) begin
      gen_addr  <= addr_up_down ? gen_addr + 1'b1 : gen_addr - 1'b1;
      gen_carry <= addr_up_down ? (gen_addr == AW'(NW - 2)) : (gen_addr == AW'(1));
    end else begin
      gen_carry <= 1'b0;
    end
  end

  logic [DW-1:0] mem [NW];
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[gen_addr];
    if (mem_we) mem[gen_addr] <= faulty(gen_addr, mem_wdata);
  end

  typedef struct packed {
    logic          a_rst, a_pre, a_en, up, re, we;
    logic [DW-1:0] wdata;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [AW-1:0] addr;
  } obs_t;

  typedef struct {
    obs_t o;
    bit   chk;
  } exp_t;

  // March C- table: direction, read background (-1 none), write background (-1 none)
  int el_up [6] = '{1, 1, 1, 0, 0, 1};
  int el_rd [6] = '{-1, 0, 1, 0, 1, 0};
  int el_wr [6] = '{0, 1, 0, 1, 0, -1};

  exp_t          exp_q[$];
  exp_t          last_exp;
  int            vectors = 0;
  int            miscompares = 0;
  int            run_cyc;
  int            obs_writes, obs_reads, obs_done_cyc;
  int            mdl_writes, mdl_reads, mdl_done_idx;
  logic          mdl_fail;
  logic [AW-1:0] mdl_fail_addr;
  logic [2:0]    mdl_fail_elem;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({addr_reset, addr_preset, addr_en, addr_up_down, mem_re, mem_we, mem_wdata,
                busy, done, fail, fail_addr, fail_elem});
  endfunction

  function automatic exp_t blank(input logic f, input logic [AW-1:0] fa, input logic [2:0] fe);
    exp_t e;
    e.o           = '0;
    e.chk         = 1'b0;
    e.o.busy      = 1'b1;
    e.o.fail      = f;
    e.o.fail_addr = fa;
    e.o.fail_elem = fe;
    return e;
  endfunction

  // Walk the algorithm once, emitting what every cycle of the run must show.
  task automatic build_trace();
    logic [DW-1:0] m [NW];
    logic [DW-1:0] bg;
    logic          f;
    logic [AW-1:0] fa;
    logic [2:0]    fe;
    int            a;
    bit            stop;
    exp_t          e;
    f = 1'b0; fa = '0; fe = '0; stop = 1'b0;
    mdl_writes = 0; mdl_reads = 0;
    exp_q.delete();
    for (int k = 0; k < NW; k++) m[k] = '0;
    for (int el = 0; el < 6 && !stop; el++) begin
      e = blank(f, fa, fe);
      e.o.a_rst = (el_up[el] == 1);
      e.o.a_pre = (el_up[el] == 0);
      exp_q.push_back(e);
      for (int k = 0; k < NW && !stop; k++) begin
        a = (el_up[el] == 1) ? k : NW - 1 - k;
        if (el_rd[el] >= 0) begin
          e = blank(f, fa, fe);
          e.o.re = 1'b1; e.chk = 1'b1; e.o.addr = AW'(a);
          exp_q.push_back(e);
          mdl_reads++;
          exp_q.push_back(blank(f, fa, fe));
          bg = (el_rd[el] == 1) ? '1 : '0;
          if (m[a] != bg) begin
            if (!f) begin
              f = 1'b1; fa = AW'(a); fe = 3'(el);
            end
`ifdef MARCH_STOP_ON_FAIL_EN
            stop = 1'b1;
`endif
          end
        end
        if (!stop && el_wr[el] >= 0) begin
          bg = (el_wr[el] == 1) ? '1 : '0;
          e = blank(f, fa, fe);
          e.o.we = 1'b1; e.o.wdata = bg; e.chk = 1'b1; e.o.addr = AW'(a);
          exp_q.push_back(e);
          mdl_writes++;
          m[a] = faulty(AW'(a), bg);
        end
        if (!stop) begin
          e = blank(f, fa, fe);
          e.o.a_en = (k != NW - 1);
          e.o.up   = e.o.a_en && (el_up[el] == 1);
          exp_q.push_back(e);
        end
      end
    end
    mdl_done_idx  = exp_q.size();
    mdl_fail      = f;
    mdl_fail_addr = fa;
    mdl_fail_elem = fe;
    repeat (3) begin
      e = blank(f, fa, fe);
      e.o.busy = 1'b0;
      e.o.done = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // One clock: compare on the falling edge, then release for input changes.
  task automatic tick();
    exp_t e;
    obs_t o;
    @(negedge clk);
    run_cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_exp = e;
      o = '0;
      o.a_rst     = addr_reset;
      o.a_pre     = addr_preset;
      o.a_en      = addr_en;
      o.up        = e.o.a_en ? addr_up_down : 1'b0;
      o.re        = mem_re;
      o.we        = mem_we;
      o.wdata     = e.o.we ? mem_wdata : '0;
      o.busy      = busy;
      o.done      = done;
      o.fail      = fail;
      o.fail_addr = fail_addr;
      o.fail_elem = fail_elem;
      o.addr      = e.chk ? gen_addr : '0;
      check($sformatf("cycle%0d", run_cyc), 32'(o), 32'(e.o));
      if (mem_we) obs_writes++;
      if (mem_re) obs_reads++;
      if (done && obs_done_cyc < 0) obs_done_cyc = run_cyc;
    end
    #1;
  endtask

  task automatic run(input int rst_at, input int start_at);
    build_trace();
    obs_writes = 0; obs_reads = 0; obs_done_cyc = -1; run_cyc = 0;
    start = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) begin
      tick();
      start = 1'b0;
      if (run_cyc == start_at && last_exp.o.busy) start = 1'b1;
      if (run_cyc == rst_at) begin
        exp_q.delete();
        reset = 1'b1;
        #1;
        check("reset_outputs_midrun", outs(), 32'd0);
        tick();
        tick();
        reset = 1'b0;
      end
    end
    start = 1'b0;
    check("trace_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    flt_en = 1'b0; flt_addr = '0; flt_bit = 0; flt_val = 1'b0;
    tick();
    tick();
    check("reset_outputs", outs(), 32'd0);
    reset = 1'b0;
    tick();

    // Fault-free run; five write elements and five read elements over four words
    run(-1, -1);
    check("model_done_cycle", 32'(mdl_done_idx + 1), 32'd91);
    check("model_writes", 32'(mdl_writes), 32'd20);
    check("model_reads", 32'(mdl_reads), 32'd20);
    check("dut_done_cycle", 32'(obs_done_cyc), 32'd91);
    check("dut_writes", 32'(obs_writes), 32'd20);
    check("dut_reads", 32'(obs_reads), 32'd20);
    check("dut_fail_clean", 32'(fail), 32'd0);

    // Stuck-at-1 on bit 0 of word 2: first caught by M1 r0 at address 2
    flt_en = 1'b1; flt_addr = 2'd2; flt_bit = 0; flt_val = 1'b1;
    run(-1, -1);
    check("model_fail", 32'(mdl_fail), 32'd1);
    check("model_fail_addr", 32'(mdl_fail_addr), 32'd2);
    check("model_fail_elem", 32'(mdl_fail_elem), 32'd1);
`ifdef MARCH_STOP_ON_FAIL_EN
    check("dut_done_cycle_sa1", 32'(obs_done_cyc), 32'd21);
`else
    check("dut_done_cycle_sa1", 32'(obs_done_cyc), 32'd91);
`endif
    check("dut_fail_sa1", 32'(fail), 32'd1);
    check("dut_fail_addr_sa1", 32'(fail_addr), 32'd2);
    check("dut_fail_elem_sa1", 32'(fail_elem), 32'd1);

    // Restart from DONE with an extra start mid-run that must be ignored
    flt_en = 1'b0;
    run(-1, 40);
    check("dut_done_cycle_restart", 32'(obs_done_cyc), 32'd91);
    check("dut_fail_cleared", 32'(fail), 32'd0);

    // Reset mid-run, then a clean rerun from IDLE
    run(30, -1);
    run(-1, -1);
    check("dut_done_cycle_after_reset", 32'(obs_done_cyc), 32'd91);

    // Random faults, spurious starts and occasional resets
    for (int r = 0; r < 12; r++) begin
      flt_en   = ($urandom_range(0, 1) == 1);
      flt_addr = AW'($urandom_range(0, NW - 1));
      flt_bit  = int'($urandom_range(0, DW - 1));
      flt_val  = 1'($urandom_range(0, 1));
      run(($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 80)) : -1,
          int'($urandom_range(2, 85)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
